mem_dump_reader: RTL and testbench

Bus-master readback engine for the 5-bit-address / 16-bit-data RAM bus shared with `CUmodule` and the test loader. On `start`, it requests the RAM bus and reads a contiguous, wrapping address range word by word. Each word is presented with its address on a valid/ready output stream, so RAM contents (program, operands, results) can be dumped after a run. It is the read-side counterpart of the external RAM loader: the loader writes memory before `enable`, and this block reads it back.

---
 rtl/mem_dump_reader_if.sv | 29 ++
 rtl/mem_dump_reader.sv | 118 +++++++++++
 tb/tb_mem_dump_reader.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_dump_reader_if.sv
// RAM bus and word-stream signals of the memory dump reader.
// The master side is the reader; the slave side is the RAM mux plus the stream consumer.
interface mem_dump_reader_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 16
);
   logic              bus_req;
   logic              bus_gnt;
   logic [ADDR_W-1:0] addressbus;
   logic              read;
   logic              write;
   logic [DATA_W-1:0] databus;
   logic [DATA_W-1:0] out_data;
   logic [ADDR_W-1:0] out_addr;
   logic              out_valid;
   logic              out_ready;

   // out_valid/out_ready: a word transfers on every rising edge where both are high;
   // once out_valid is up, out_data/out_addr stay put until that edge.
   modport master (
      output bus_req, addressbus, read, write, out_data, out_addr, out_valid,
      input  bus_gnt, databus, out_ready
   );

   modport slave (
      input  bus_req, addressbus, read, write, out_data, out_addr, out_valid,
      output bus_gnt, databus, out_ready
   );
endinterface

// File: rtl/mem_dump_reader.sv
// Bus-master readback engine: reads a wrapping RAM address range and streams
// each word with its address over a valid/ready channel.
module mem_dump_reader #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 16,
   parameter int RD_LAT = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [ADDR_W-1:0]   start_addr,
   input  logic [ADDR_W-1:0]   end_addr,
   mem_dump_reader_if.master   bus,
   output logic                busy,
   output logic                done,
   output logic [2:0]          state_dbg
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_REQ  = 3'd1;
   localparam logic [2:0] S_RD   = 3'd2;
   localparam logic [2:0] S_WAIT = 3'd3;
   localparam logic [2:0] S_OUT  = 3'd4;
   localparam logic [2:0] S_DONE = 3'd5;

   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] cur_q, cur_d;
   logic [ADDR_W-1:0] last_q, last_d;
   logic [1:0]        cnt_q, cnt_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic [ADDR_W-1:0] out_addr_q, out_addr_d;
   logic              rd_phase;

   always_comb begin
      state_d    = state_q;
      cur_d      = cur_q;
      last_d     = last_q;
      cnt_d      = cnt_q;
      out_data_d = out_data_q;
      out_addr_d = out_addr_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               cur_d   = start_addr;
               last_d  = end_addr;
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            if (bus.bus_gnt) state_d = S_RD;
         end
         S_RD: begin
            if (!bus.bus_gnt) begin
               state_d = S_REQ;
            end else begin
               cnt_d   = 2'(RD_LAT - 1);
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            // Losing the grant mid-read discards the access; the word is re-read after regrant.
            if (!bus.bus_gnt) begin
               state_d = S_REQ;
            end else if (cnt_q == 2'd0) begin
               out_data_d = bus.databus;
               out_addr_d = cur_q;
               state_d    = S_OUT;
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end
         S_OUT: begin
            if (bus.out_ready) begin
               if (cur_q == last_q) begin
                  state_d = S_DONE;
               end else begin
                  cur_d   = cur_q + 1'b1;
                  state_d = S_RD;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cur_q      <= '0;
         last_q     <= '0;
         cnt_q      <= '0;
         out_data_q <= '0;
         out_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         cur_q      <= cur_d;
         last_q     <= last_d;
         cnt_q      <= cnt_d;
         out_data_q <= out_data_d;
         out_addr_q <= out_addr_d;
      end
   end

   // read follows the grant combinationally so a revoked grant frees the bus at once.
   assign rd_phase       = (state_q == S_RD) || (state_q == S_WAIT);
   assign bus.read       = rd_phase && bus.bus_gnt;
   assign bus.addressbus = bus.read ? cur_q : '0;
   assign bus.write      = 1'b0;
   assign bus.bus_req    = (state_q == S_REQ) || rd_phase || (state_q == S_OUT);
   assign bus.out_valid  = (state_q == S_OUT);
   assign bus.out_data   = out_data_q;
   assign bus.out_addr   = out_addr_q;
   assign busy           = (state_q != S_IDLE);
   assign done           = (state_q == S_DONE);
   assign state_dbg      = state_q;

endmodule

// File: tb/tb_mem_dump_reader.sv
// Randomized scoreboard bench for mem_dump_reader: a behavioural RAM, grant/ready
// drivers, and a monitor that compares every streamed word against expectations.
module tb_mem_dump_reader;
  localparam int AW = 5;
  localparam int DW = 16;
  localparam int RD_LAT = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW-1:0] end_addr = '0;
  logic          busy;
  logic          done;
  logic [2:0]    state_dbg;

  mem_dump_reader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_dump_reader #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_addr (start_addr),
    .end_addr   (end_addr),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- behavioural RAM (one-edge read latency) ----------------
  logic [DW-1:0] mem [0:31];
  logic [DW-1:0] rd_data = '0;
  always @(posedge clk) if (bus.read) rd_data <= mem[bus.addressbus];
  assign bus.databus = rd_data;

  // ---------------- scoreboard state ----------------
  logic [AW+DW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int drops_seen = 0;

  bit rdy_rand = 0, gnt_rand = 0, ready_low = 0, stall_en = 0, drop_en = 0;
  logic [AW-1:0] stall_addr = '0, drop_addr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- grant / ready driver ----------------
  initial begin
    int stall_left;
    bit dropped;
    int gnt_hold;
    bit read_prev;
    bus.out_ready = 1'b1;
    bus.bus_gnt = 1'b1;
    stall_left = 4;
    dropped = 0;
    gnt_hold = 0;
    read_prev = 0;
    forever begin
      @(posedge clk); #1;
      if (!stall_en) stall_left = 4;
      if (!drop_en) dropped = 0;
      if (ready_low)
        bus.out_ready = 1'b0;
      else if (stall_en && stall_left > 0 && bus.out_valid && bus.out_addr == stall_addr) begin
        bus.out_ready = 1'b0;
        stall_left--;
      end else
        bus.out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (gnt_hold > 0) begin
        gnt_hold--;
        bus.bus_gnt = 1'b0;
      end else if (drop_en && !dropped && bus.read && read_prev && bus.addressbus == drop_addr) begin
        // second consecutive read cycle on this address is the WAIT cycle
        bus.bus_gnt = 1'b0;
        dropped = 1;
        gnt_hold = 1;
        drops_seen++;
        #1;
        check("read_drop_immediate", {31'd0, bus.read}, 32'd0);
      end else
        bus.bus_gnt = gnt_rand ? ($urandom_range(0, 4) != 0) : 1'b1;
      read_prev = bus.read;
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic [AW+DW-1:0] prev;
    logic [AW+DW-1:0] exp;
    bit prev_stall;
    prev = '0;
    prev_stall = 0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("write_zero", {31'd0, bus.write}, 32'd0);
        if (!bus.read) check("addr_zero_no_read", {27'd0, bus.addressbus}, 32'd0);
        if (!bus.bus_gnt) check("read_needs_gnt", {31'd0, bus.read}, 32'd0);
        if (bus.out_valid) check("read_low_in_out", {31'd0, bus.read}, 32'd0);
        if (prev_stall) begin
          check("hold_valid", {31'd0, bus.out_valid}, 32'd1);
          check("hold_word", {11'd0, bus.out_addr, bus.out_data}, {11'd0, prev});
        end
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_word: got addr %0d data 0x%0h expected none", bus.out_addr, bus.out_data);
          end else begin
            exp = exp_q.pop_front();
            check("word", {11'd0, bus.out_addr, bus.out_data}, {11'd0, exp});
          end
        end
        if (done) begin
          done_cnt++;
          check("done_after_last", exp_q.size(), 32'd0);
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev = {bus.out_addr, bus.out_data};
      end else begin
        prev_stall = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_dump(input logic [AW-1:0] s, input logic [AW-1:0] e, input bit timed, input bit poke);
    int n;
    int base;
    int cyc;
    logic [AW-1:0] a;
    n = ((int'(e) - int'(s)) & 31) + 1;
    base = done_cnt;
    cyc = 0;
    for (int i = 0; i < n; i++) begin
      a = AW'((int'(s) + i) & 31);
      exp_q.push_back({a, mem[a]});
    end
    @(posedge clk); #1;
    start_addr = s;
    end_addr = e;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    start_addr = AW'($urandom);
    end_addr = AW'($urandom);
    check("bus_req_after_start", {31'd0, bus.bus_req}, 32'd1);
    while (busy && cyc < 3000) begin
      start = (poke && cyc == 2);
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    if (busy) begin
      n_cmp++;
      n_fail++;
      $display("FAIL dump_timeout: still busy after %0d cycles, expected idle", cyc);
    end
    if (timed) check("dump_cycles", cyc, n * (2 + RD_LAT) + 2);
    check("done_once", done_cnt - base, 32'd1);
    check("queue_drained", exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_bus_req"}, {31'd0, bus.bus_req}, 32'd0);
    check({tag, "_addressbus"}, {27'd0, bus.addressbus}, 32'd0);
    check({tag, "_read"}, {31'd0, bus.read}, 32'd0);
    check({tag, "_write"}, {31'd0, bus.write}, 32'd0);
    check({tag, "_out_data"}, {16'd0, bus.out_data}, 32'd0);
    check({tag, "_out_addr"}, {27'd0, bus.out_addr}, 32'd0);
    check({tag, "_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int base;
    int w;
    logic [AW-1:0] s, e;
    for (int k = 0; k < 32; k++) mem[k] = DW'($urandom);

    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // two-word dump, grant and ready held high
    mem[16] = 16'd5;
    mem[17] = 16'd2;
    run_dump(5'd16, 5'd17, 1, 0);

    // stall on the second word
    mem[1] = 16'h0086;
    mem[2] = 16'h018E;
    mem[3] = 16'h0000;
    stall_en = 1;
    stall_addr = 5'd2;
    run_dump(5'd1, 5'd3, 0, 0);
    stall_en = 0;

    // wrap-around range
    for (int k = 0; k < 32; k++) mem[k] = DW'(k + 100);
    run_dump(5'd30, 5'd1, 1, 0);

    // single word, with a start pulse while busy
    run_dump(5'd7, 5'd7, 1, 1);

    // grant revoked in the WAIT cycle of address 16
    base = drops_seen;
    drop_en = 1;
    drop_addr = 5'd16;
    run_dump(5'd15, 5'd17, 0, 0);
    drop_en = 0;
    check("grant_drop_seen", drops_seen - base, 32'd1);

    // reset while a word is being offered
    for (int k = 0; k < 32; k++) mem[k] = DW'($urandom_range(1, 65535));
    ready_low = 1;
    @(posedge clk); #1;
    start_addr = 5'd0;
    end_addr = 5'd5;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    w = 0;
    while (!bus.out_valid && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    check("reached_out", {31'd0, bus.out_valid}, 32'd1);
    base = done_cnt;
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ready_low = 0;
    repeat (2) @(posedge clk);
    check("no_done_on_abort", done_cnt - base, 32'd0);
    run_dump(5'd3, 5'd9, 1, 0);

    // randomized dumps with random grant and ready
    rdy_rand = 1;
    gnt_rand = 1;
    for (int t = 0; t < 20; t++) begin
      for (int k = 0; k < 32; k++) mem[k] = DW'($urandom);
      s = AW'($urandom);
      e = AW'(int'(s) + $urandom_range(0, 12));
      run_dump(s, e, 0, ($urandom_range(0, 1) == 1));
    end
    rdy_rand = 0;
    gnt_rand = 0;
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
